// File: rtl/lector_serial_codigo_pkg.sv
// rtl/lector_serial_codigo_pkg.sv - shared encodings, field layout and range check for the barcode reader
package lector_serial_codigo_pkg;

  localparam int N_BITS    = 12;
  localparam int DAY_W     = 5;
  localparam int MONTH_W   = 4;
  localparam int PROD_W    = 3;
  localparam int DAY_LSB   = 0;
  localparam int MONTH_LSB = 5;
  localparam int PROD_LSB  = 9;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [MONTH_W-1:0] MONTH_MIN = 4'd1;
  localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_PAR  = 2'b01,
    ERR_TO   = 2'b10,
    ERR_FRM  = 2'b11
  } err_code_t;

  // Framing/range rejection: bad stop bit, day zero or month outside 1..12
  function automatic logic frame_bad(input logic [N_BITS-1:0] w, input logic stop_bit);
    logic [DAY_W-1:0]   day;
    logic [MONTH_W-1:0] month;
    day   = w[DAY_LSB +: DAY_W];
    month = w[MONTH_LSB +: MONTH_W];
    return stop_bit || (day == '0) || (month < MONTH_MIN) || (month > MONTH_MAX);
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// rtl/contador_timeout.sv - inter-strobe timeout counter with synchronous clear
module contador_timeout #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic clr_cnt,
  input  logic inc,
  output logic expired
);

  logic [TO_W-1:0] count;

  assign expired = (count == TO_W'(TIMEOUT));

  // Saturates at TIMEOUT so a missed clear can never wrap back to a quiet count
  always_ff @(posedge clk) begin
    if (clr_cnt) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lector_serial_codigo.sv
// rtl/lector_serial_codigo.sv - serial barcode frame deserializer with parity, range and timeout checks
module lector_serial_codigo
  import lector_serial_codigo_pkg::*;
#(
  parameter int N_BITS  = 12,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              DIN,
  input  logic              DVALID,
  output logic [N_BITS-1:0] L,
  output logic              EN,
  output logic              ERR,
  output logic [1:0]        ERR_CODE,
  output logic              BUSY
);

  localparam logic [3:0] LAST_BIT = 4'(N_BITS - 1);

  logic [1:0]        state;
  logic [3:0]        bit_cnt;
  logic [N_BITS-1:0] shreg;
  logic              par_ok;
  logic              expired;
  logic              timed_out;
  logic              clr_cnt;
  logic              inc;

  assign BUSY      = (state != IDLE);
  // A strobe landing in the expiry cycle wins over the timeout
  assign timed_out = BUSY && !DVALID && expired;
  assign clr_cnt   = CLR || !BUSY || DVALID || timed_out;
  assign inc       = !DVALID;

  contador_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_contador_timeout (
    .clk     (CLK),
    .clr_cnt (clr_cnt),
    .inc     (inc),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_ok   <= 1'b0;
      L        <= '0;
      EN       <= 1'b0;
      ERR      <= 1'b0;
      ERR_CODE <= ERR_NONE;
    end else begin
      EN       <= 1'b0;
      ERR      <= 1'b0;
      ERR_CODE <= ERR_NONE;
      if (timed_out) begin
        ERR      <= 1'b1;
        ERR_CODE <= ERR_TO;
        state    <= IDLE;
        bit_cnt  <= '0;
      end else if (DVALID) begin
        case (state)
          IDLE: begin
            if (DIN) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg[bit_cnt] <= DIN;
            bit_cnt        <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_ok <= ~((^shreg) ^ DIN);
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!par_ok) begin
              ERR      <= 1'b1;
              ERR_CODE <= ERR_PAR;
            end else if (frame_bad(shreg, DIN)) begin
              ERR      <= 1'b1;
              ERR_CODE <= ERR_FRM;
            end else begin
              L  <= shreg;
              EN <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lector_serial_codigo.sv
// tb/tb_lector_serial_codigo.sv - self-checking bench for lector_serial_codigo
module tb_lector_serial_codigo;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        DIN;
  logic        DVALID;
  logic [11:0] L;
  logic        EN;
  logic        ERR;
  logic [1:0]  ERR_CODE;
  logic        BUSY;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [11:0] l_model;

  typedef struct {
    logic       is_err;
    logic [1:0] code;
    logic [11:0] l;
    int         cycle;
  } exp_t;

  typedef struct {
    logic [11:0] word;
    logic        pflip;
    logic        stp;
    logic        exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];
  logic [14:0] f;

  lector_serial_codigo #(
    .N_BITS  (12),
    .TIMEOUT (255),
    .TO_W    (8)
  ) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .DIN      (DIN),
    .DVALID   (DVALID),
    .L        (L),
    .EN       (EN),
    .ERR      (ERR),
    .ERR_CODE (ERR_CODE),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [14:0] mk(input logic [11:0] w, input logic pflip, input logic stp);
    return {stp, (^w) ^ pflip, w, 1'b1};
  endfunction

  task automatic drive_bits(input logic [14:0] fr, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      DVALID = 1'b1;
      DIN    = fr[i];
      @(posedge CLK);
      #1;
    end
    DVALID = 1'b0;
    DIN    = 1'b0;
  endtask

  task automatic idle(input int n);
    DVALID = 1'b0;
    DIN    = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [1:0] code, input int delay);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.l      = l_model;
    e.cycle  = cyc + delay;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    idle(4);
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: every EN/ERR strobe must match the next expected event, at the expected cycle
  always @(negedge CLK) begin
    if (EN === 1'b1 || ERR === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_strobe", 32'({EN, ERR}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_err", 32'(ERR), 32'(mon_e.is_err));
        check("strobe_en", 32'(EN), 32'(!mon_e.is_err));
        check("err_code", 32'(ERR_CODE), 32'(mon_e.code));
        check("l_value", 32'(L), 32'(mon_e.l));
        check("latency", 32'(cyc), 32'(mon_e.cycle));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{12'hA59, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[1] = '{12'hA59, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[2] = '{12'hBA1, 1'b0, 1'b0, 1'b1, 2'b11};
    vecs[3] = '{12'hA40, 1'b0, 1'b0, 1'b1, 2'b11};
    vecs[4] = '{12'hA59, 1'b0, 1'b1, 1'b1, 2'b11};
    vecs[5] = '{12'hA19, 1'b0, 1'b0, 1'b1, 2'b11};
    vecs[6] = '{12'hF9F, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[7] = '{12'h321, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[8] = '{12'hF9F, 1'b1, 1'b1, 1'b1, 2'b01};

    CLR     = 1'b1;
    DIN     = 1'b0;
    DVALID  = 1'b0;
    l_model = 12'h000;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_l", 32'(L), 32'd0);
    check("rst_en", 32'(EN), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_code", 32'(ERR_CODE), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    CLR = 1'b0;

    // Idle line: zeros with DVALID and ones without DVALID never start a frame
    DVALID = 1'b1;
    DIN    = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check("idle_zero_busy", 32'(BUSY), 32'd0);
    DVALID = 1'b0;
    DIN    = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check("idle_nostrobe_busy", 32'(BUSY), 32'd0);

    for (int i = 0; i < 9; i++) begin
      f = mk(vecs[i].word, vecs[i].pflip, vecs[i].stp);
      drive_bits(f, 0, 13);
      check($sformatf("busy_vec%0d", i), 32'(BUSY), 32'd1);
      drive_bits(f, 14, 14);
      if (!vecs[i].exp_err) l_model = vecs[i].word;
      push_exp(vecs[i].exp_err, vecs[i].exp_code, 0);
      drain($sformatf("drain_vec%0d", i));
    end

    // Timeout: start + 5 data bits, then silence
    f = mk(12'h321, 1'b0, 1'b0);
    drive_bits(f, 0, 5);
    check("to_busy_before", 32'(BUSY), 32'd1);
    push_exp(1'b1, 2'b10, 256);
    idle(300);
    check("to_busy_after", 32'(BUSY), 32'd0);
    check("to_drain", 32'(sb.size()), 32'd0);
    f = mk(12'h321, 1'b0, 1'b0);
    drive_bits(f, 0, 14);
    l_model = 12'h321;
    push_exp(1'b0, 2'b00, 0);
    drain("after_to_frame");

    // Strobe arriving in the very cycle the count reaches TIMEOUT cancels it
    f = mk(12'hF9F, 1'b0, 1'b0);
    drive_bits(f, 0, 3);
    idle(255);
    drive_bits(f, 4, 14);
    l_model = 12'hF9F;
    push_exp(1'b0, 2'b00, 0);
    drain("to_cancel_frame");

    // Reset mid-frame discards the partial frame silently
    f = mk(12'hA59, 1'b0, 1'b0);
    drive_bits(f, 0, 7);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    l_model = 12'h000;
    check("midrst_l", 32'(L), 32'd0);
    check("midrst_en", 32'(EN), 32'd0);
    check("midrst_err", 32'(ERR), 32'd0);
    check("midrst_code", 32'(ERR_CODE), 32'd0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    CLR = 1'b0;
    idle(3);
    f = mk(12'h321, 1'b0, 1'b0);
    drive_bits(f, 0, 14);
    l_model = 12'h321;
    push_exp(1'b0, 2'b00, 0);
    drain("after_midrst_frame");

    // Back-to-back frames with continuous DVALID
    f = mk(12'hA59, 1'b0, 1'b0);
    drive_bits(f, 0, 14);
    l_model = 12'hA59;
    push_exp(1'b0, 2'b00, 0);
    f = mk(12'h321, 1'b0, 1'b0);
    drive_bits(f, 0, 14);
    l_model = 12'h321;
    push_exp(1'b0, 2'b00, 0);
    drain("b2b_drain");

    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lector_serial_codigo.md
Name: lector_serial_codigo

Overview:
- Upstream stage of the 12-bit barcode register. Deserializes the scanner's serial bit stream into the 12-bit word {product[2:0], month[3:0], day[4:0]}.
- Checks framing, parity and field ranges on each frame.
- For an accepted frame, presents L[11:0] and pulses EN for one cycle so the register captures it. Rejected frames produce an error pulse instead.

Parameters:
- N_BITS, 12, data bits per frame; fixed by the register width, must not be overridden.
- TIMEOUT, 255, maximum CLK cycles allowed between DVALID strobes inside a frame.
- TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- CLK  input  1  system clock, rising edge.
- CLR  input  1  reset, synchronous, active-high.
- DIN  input  1  serial data bit from the scanner, sampled only when DVALID=1.
- DVALID  input  1  bit-valid strobe; each CLK cycle with DVALID=1 consumes one bit.
- L  output  12  last accepted word: [4:0] day, [8:5] month, [11:9] product.
- EN  output  1  one-cycle load strobe to the register.
- ERR  output  1  one-cycle error strobe.
- ERR_CODE  output  2  error cause, valid while ERR=1: 01 parity, 10 timeout, 11 stop/range; 00 otherwise.
- BUSY  output  1  high while a frame is in progress (state not IDLE).

Behaviour:
- Reset (CLR=1 at a rising edge): state=IDLE, bit counter=0, timeout counter=0, shift register=0, L=0, EN=0, ERR=0, ERR_CODE=00, BUSY=0. CLR overrides every other input, including mid-frame; a partial frame is discarded with no ERR.
- Frame format, in DVALID-qualified bits:
  - start bit = 1;
  - 12 data bits, LSB first (L[0] first);
  - even parity bit: the XOR of the 12 data bits and the parity bit must be 0;
  - stop bit = 0.
- States and transitions:
  - IDLE: DVALID&DIN=1 -> DATA, counter=0. DVALID&DIN=0 is ignored (line idle).
  - DATA: on each DVALID, shift DIN into bit position counter and increment. On the 12th bit (counter=11) -> PARITY.
  - PARITY: on DVALID, latch the parity result -> STOP.
  - STOP: on DVALID, evaluate the frame -> IDLE.
- Evaluation in the STOP cycle, in priority order:
  1. Parity fail -> ERR code 01.
  2. Stop bit = 1, day = 0, or month outside 1..12 -> ERR code 11.
  3. Otherwise accept: L <= shift register and EN=1.
- Output timing: EN and ERR assert on the cycle after the stop bit is sampled (registered outputs). Each is high for exactly one cycle; they are never high together.
- L update: L changes only on an accepted frame and is stable otherwise. L and EN assert in the same cycle, so the register captures the new L on the following edge.
- Timeout:
  - The counter clears on every DVALID and increments on every non-DVALID cycle while in DATA/PARITY/STOP.
  - When it reaches TIMEOUT, the next cycle gives ERR=1, code 10, state -> IDLE, counter=0.
  - A DVALID arriving in the same cycle the count reaches TIMEOUT is consumed and the timeout is cancelled.
  - The counter is held at 0 in IDLE.
- Back-to-back frames: a start bit may arrive in the cycle immediately after the stop bit. It is accepted, because the state is already IDLE in that cycle.
- DIN is ignored whenever DVALID=0. There is no oversampling; the scanner front end guarantees clean strobes.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3;
  - field widths: DAY_W=5, MONTH_W=4, PROD_W=3, N_BITS=12;
  - field offsets: DAY_LSB=0, MONTH_LSB=5, PROD_LSB=9;
  - error codes: ERR_NONE, ERR_PAR, ERR_TO, ERR_FRM;
  - month limits 1..12.
- Sub-module contador_timeout: TO_W-bit counter with inputs clr_cnt and inc and output expired (count==TIMEOUT). It is instantiated once.
- FSM, shift register and checks stay in the top module.

Test Plan:
- Valid frame: day=25, month=2, product=5 (word 0xA59). Send start 1, data bits LSB first 1,0,0,1,1,0,1,0,0,1,0,1, parity 0, stop 0. -> EN=1 for one cycle after the stop bit, L=0xA59, ERR=0.
- Parity error: same frame with parity bit 1. -> ERR=1, ERR_CODE=01, EN=0, L keeps its previous value.
- Range error: month=13 (word 0xBA1), correct parity. -> ERR=1, ERR_CODE=11, no EN; repeat with day=0 and with stop bit=1, expecting the same result.
- Timeout: start bit plus 5 data bits, then DVALID=0 for 300 cycles. -> ERR=1, code 10, exactly TIMEOUT+1 cycles after the last strobe; BUSY=0 afterwards; the next valid frame is accepted.
- Reset mid-frame: CLR=1 after 7 data bits. -> on the next edge all outputs are 0 and state is IDLE, with no ERR; a following valid frame gives EN with the correct L.
- Back-to-back frames: 0xA59, then 0x321 (day 1, month 9, product 1), with continuous DVALID. -> two EN pulses 15 cycles apart, L=0xA59 then 0x321.
